// File: rtl/roll_arbiter_if.sv
// Requester-side bus of the dice-roll arbiter: request/accept plus the response strobe.
// master is the requester side; slave is the arbiter side.
interface roll_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int RESULT_W = 5
);
    logic [N_REQ-1:0]    req_valid;
    logic [4*N_REQ-1:0]  req_die;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [RESULT_W-1:0] rsp_data;
    logic                rsp_err;

    modport master (
        output req_valid, req_die,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_die,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/roll_arbiter.sv
// Round-robin arbiter sharing one dice-roll engine between N_REQ requesters, with engine timeout.
// Optional macro ROLL_ARB_DIE_CHECK_EN answers invalid die codes locally instead of starting the engine.
module roll_arbiter #(
    parameter int N_REQ          = 4,
    parameter int RESULT_W       = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    roll_arbiter_if.slave       req_bus,
    output logic                eng_start,
    output logic [3:0]          eng_die,
    output logic                eng_abort,
    input  logic                eng_done,
    input  logic [RESULT_W-1:0] eng_result,
    output logic                busy
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             win_bad;
    logic [3:0]       win_die;
    logic [3:0]       die_lat;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Scan requesters starting at rr_ptr; the first one asserting req_valid wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!win_found && req_bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_die = req_bus.req_die[{win_idx, 2'b00} +: 4];

`ifdef ROLL_ARB_DIE_CHECK_EN
    assign win_bad = (win_die > 4'd5);
`else
    assign win_bad = 1'b0;
`endif

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_found) next_state = win_bad ? RESP : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (eng_done || timeout_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the transition being taken, so each appears in the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr            <= '0;
            grant             <= '0;
            die_lat           <= 4'hF;
            wait_cnt          <= '0;
            req_bus.req_ready <= '0;
            req_bus.rsp_valid <= '0;
            req_bus.rsp_data  <= '0;
            req_bus.rsp_err   <= 1'b0;
            eng_start         <= 1'b0;
            eng_abort         <= 1'b0;
            eng_die           <= 4'hF;
            busy              <= 1'b0;
        end else begin
            req_bus.req_ready <= '0;
            req_bus.rsp_valid <= '0;
            req_bus.rsp_data  <= '0;
            req_bus.rsp_err   <= 1'b0;
            eng_start         <= 1'b0;
            eng_abort         <= 1'b0;
            eng_die           <= 4'hF;
            busy              <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant                      <= win_idx;
                        die_lat                    <= win_die;
                        req_bus.req_ready[win_idx] <= 1'b1;
                        if (win_bad) begin
                            req_bus.rsp_valid[win_idx] <= 1'b1;
                            req_bus.rsp_err            <= 1'b1;
                        end else begin
                            eng_start <= 1'b1;
                            eng_die   <= win_die;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    eng_die  <= die_lat;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A result arriving in the timeout cycle still counts as a good roll.
                    if (eng_done) begin
                        req_bus.rsp_valid[grant] <= 1'b1;
                        req_bus.rsp_data         <= eng_result;
                    end else if (timeout_hit) begin
                        req_bus.rsp_valid[grant] <= 1'b1;
                        req_bus.rsp_err          <= 1'b1;
                        eng_abort                <= 1'b1;
                    end else begin
                        eng_die <= die_lat;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_roll_arbiter.sv
// Scoreboard bench for roll_arbiter: a round-robin reference model predicts grants and responses,
// a monitor checks them as the DUT emits them. Define ROLL_ARB_DIE_CHECK_EN for both RTL and bench together.
module tb_roll_arbiter;
    localparam int N_REQ    = 4;
    localparam int RESULT_W = 5;
    localparam int TIMEOUT  = 16;
    localparam int DEPTH    = 64;

`ifdef ROLL_ARB_DIE_CHECK_EN
    localparam bit DIE_CHECK = 1'b1;
`else
    localparam bit DIE_CHECK = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [3:0] die;
        bit         start;
    } grant_exp_t;

    typedef struct {
        int                  idx;
        logic [RESULT_W-1:0] data;
        bit                  err;
        bit                  abort;
        int                  lat;
    } rsp_exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                eng_start;
    logic [3:0]          eng_die;
    logic                eng_abort;
    logic                eng_done = 1'b0;
    logic [RESULT_W-1:0] eng_result = '0;
    logic                busy;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ready = 0;
    bit mon_en = 1'b0;
    int model_ptr = 0;

    grant_exp_t gq[$];
    rsp_exp_t   rq[$];

    logic [3:0]          f_die [N_REQ][DEPTH];
    int                  f_lat [N_REQ][DEPTH];
    logic [RESULT_W-1:0] f_val [N_REQ][DEPTH];
    int                  f_head[N_REQ] = '{default: 0};
    int                  f_tail[N_REQ] = '{default: 0};

    logic [3:0]          st_die[N_REQ][4];
    int                  st_lat[N_REQ][4];
    logic [RESULT_W-1:0] st_val[N_REQ][4];
    int                  st_cnt[N_REQ] = '{default: 0};

    int                  eng_cnt = 0;
    logic [RESULT_W-1:0] eng_val = '0;
    int                  ag_g;
    int                  ag_slot;

    roll_arbiter_if #(.N_REQ(N_REQ), .RESULT_W(RESULT_W)) bus ();

    roll_arbiter #(
        .N_REQ(N_REQ),
        .RESULT_W(RESULT_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_bus(bus),
        .eng_start(eng_start),
        .eng_die(eng_die),
        .eng_abort(eng_abort),
        .eng_done(eng_done),
        .eng_result(eng_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Requesters and engine model: requests are held until accepted, engine answers after the record's latency.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = eng_val;
            end
        end
        if (eng_start) begin
            ag_g = -1;
            for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) ag_g = i;
            if (ag_g >= 0 && f_head[ag_g] != f_tail[ag_g]) begin
                ag_slot = f_head[ag_g] % DEPTH;
                eng_cnt = f_lat[ag_g][ag_slot];
                eng_val = f_val[ag_g][ag_slot];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_ready[i] && f_head[i] != f_tail[i]) f_head[i]++;
        end
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i]      = (f_head[i] != f_tail[i]);
            bus.req_die[4*i +: 4] = bus.req_valid[i] ? f_die[i][f_head[i] % DEPTH] : 4'hF;
        end
    end

    // Monitor: pops expectations whenever the DUT accepts a request or presents a response.
    always @(negedge clk) begin
        grant_exp_t ge;
        rsp_exp_t   re;
        if (mon_en) begin
            if (bus.req_ready != '0 || eng_start) begin
                if (gq.size() == 0) begin
                    checkOutput("unexpected_grant", {bus.req_ready, eng_start}, 32'd0);
                end else begin
                    ge = gq.pop_front();
                    checkOutput("grant_ready", bus.req_ready, N_REQ'(1) << ge.idx);
                    checkOutput("grant_eng_start", eng_start, ge.start);
                    checkOutput("grant_eng_die", eng_die, ge.start ? ge.die : 4'hF);
                    checkOutput("grant_busy", busy, 1);
                end
                last_ready = cyc;
            end
            if (bus.rsp_valid != '0) begin
                if (rq.size() == 0) begin
                    checkOutput("unexpected_rsp", bus.rsp_valid, 32'd0);
                end else begin
                    re = rq.pop_front();
                    checkOutput("rsp_valid", bus.rsp_valid, N_REQ'(1) << re.idx);
                    checkOutput("rsp_data", bus.rsp_data, re.data);
                    checkOutput("rsp_err", bus.rsp_err, re.err);
                    checkOutput("rsp_abort", eng_abort, re.abort);
                    checkOutput("rsp_latency", cyc - last_ready, re.lat);
                    checkOutput("rsp_busy", busy, 1);
                end
            end else begin
                checkOutput("quiet_outputs", {bus.rsp_data, bus.rsp_err, eng_abort}, 32'd0);
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, bus.req_ready, 0);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_rsp_data"}, bus.rsp_data, 0);
        checkOutput({tag, "_rsp_err"}, bus.rsp_err, 0);
        checkOutput({tag, "_eng_start"}, eng_start, 0);
        checkOutput({tag, "_eng_abort"}, eng_abort, 0);
        checkOutput({tag, "_eng_die"}, eng_die, 4'hF);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Stage one request record: lat > TIMEOUT means the engine never answers in time.
    task automatic applyStimulus(input int who, input logic [3:0] die, input int lat,
                                 input logic [RESULT_W-1:0] val);
        st_die[who][st_cnt[who]] = die;
        st_lat[who][st_cnt[who]] = lat;
        st_val[who][st_cnt[who]] = val;
        st_cnt[who]++;
    endtask

    // Predict the service order of all staged requests, release them, and wait for the round to drain.
    task automatic runRound();
        int srv[N_REQ];
        int remaining;
        int w;
        int n;
        bit bad;
        grant_exp_t ge;
        rsp_exp_t   re;
        @(negedge clk);
        remaining = 0;
        for (int i = 0; i < N_REQ; i++) begin
            srv[i] = 0;
            remaining += st_cnt[i];
        end
        n = remaining;
        while (remaining > 0) begin
            w = -1;
            for (int k = 0; k < N_REQ && w < 0; k++) begin
                if (srv[(model_ptr + k) % N_REQ] < st_cnt[(model_ptr + k) % N_REQ]) w = (model_ptr + k) % N_REQ;
            end
            ge.idx = w;
            ge.die = st_die[w][srv[w]];
            bad = DIE_CHECK && (ge.die > 4'd5);
            ge.start = !bad;
            re.idx = w;
            if (bad) begin
                re.data = '0; re.err = 1'b1; re.abort = 1'b0; re.lat = 0;
            end else if (st_lat[w][srv[w]] > TIMEOUT) begin
                re.data = '0; re.err = 1'b1; re.abort = 1'b1; re.lat = TIMEOUT + 1;
            end else begin
                re.data = st_val[w][srv[w]]; re.err = 1'b0; re.abort = 1'b0;
                re.lat = st_lat[w][srv[w]] + 1;
            end
            gq.push_back(ge);
            rq.push_back(re);
            srv[w]++;
            remaining--;
            model_ptr = (w + 1) % N_REQ;
        end
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < st_cnt[i]; j++) begin
                f_die[i][f_tail[i] % DEPTH] = st_die[i][j];
                f_lat[i][f_tail[i] % DEPTH] = st_lat[i][j];
                f_val[i][f_tail[i] % DEPTH] = st_val[i][j];
                f_tail[i]++;
            end
            st_cnt[i] = 0;
        end
        for (int c = 0; c < 30 * n + 40 && (gq.size() > 0 || rq.size() > 0); c++) @(negedge clk);
        checkOutput("round_drained", gq.size() + rq.size(), 0);
        gq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_eng_die", eng_die, 4'hF);
        checkOutput("idle_req_valid", bus.req_valid, 0);
    endtask

    task automatic resetMidRoll();
        grant_exp_t ge;
        @(negedge clk);
        ge.idx = 2; ge.die = 4'd2; ge.start = 1'b1;
        gq.push_back(ge);
        f_die[2][f_tail[2] % DEPTH] = 4'd2;
        f_lat[2][f_tail[2] % DEPTH] = 12;
        f_val[2][f_tail[2] % DEPTH] = 5'd9;
        f_tail[2]++;
        for (int c = 0; c < 20 && gq.size() > 0; c++) @(negedge clk);
        checkOutput("midreset_grant", gq.size(), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("midreset");
        reset = 1'b0;
        model_ptr = 0;
        repeat (15) @(negedge clk);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_eng_die", eng_die, 4'hF);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int lat;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        applyStimulus(0, 4'd5, 5, 5'd17);
        runRound();

        applyStimulus(3, 4'd1, 2, 5'd4);
        runRound();

        for (int i = 0; i < N_REQ; i++) begin
            applyStimulus(i, 4'($urandom_range(0, 5)), $urandom_range(1, 6), 5'($urandom_range(1, 20)));
            applyStimulus(i, 4'($urandom_range(0, 5)), $urandom_range(1, 6), 5'($urandom_range(1, 20)));
        end
        runRound();

        applyStimulus(1, 4'd3, TIMEOUT + 1, 5'd12);
        applyStimulus(1, 4'd2, 3, 5'd7);
        runRound();

        applyStimulus(3, 4'd0, TIMEOUT, 5'd3);
        runRound();

        resetMidRoll();

        for (int i = 0; i < N_REQ; i++) applyStimulus(i, 4'd4, 2, 5'(10 + i));
        runRound();

        applyStimulus(2, 4'd9, 4, 5'd11);
        runRound();

        for (int round = 0; round < 15; round++) begin
            for (int i = 0; i < N_REQ; i++) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    r = $urandom_range(0, 9);
                    lat = (r == 0) ? TIMEOUT + 1 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
                    applyStimulus(i, 4'($urandom_range(0, 15)), lat, 5'($urandom_range(0, 31)));
                end
            end
            runRound();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
